// File: rtl/dfr0520_cmd_sequencer.sv
// dfr0520_cmd_sequencer
// Buffers wiper-write / shutdown requests and feeds them one at a time to the
// DFR0520 SPI transmitter. Each frame is tracked through the transmitter's CS
// line, and per-pot shadow registers hold the last successfully written value.
// GAP_CYCLES and TIMEOUT must both be at least 1.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for a queued request (only after ARMED is set)
// S_LOAD      | EN pulse cycle; cmd/sel/data already stable
// S_WAIT_LOW  | waiting for CS to fall, bounded by the timeout counter
// S_WAIT_HIGH | frame in progress; CS rising ends it and commits shadows
// S_GAP       | mandatory idle time before the next EN
module dfr0520_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_cmd,
  input  logic [1:0]                    req_sel,
  input  logic [7:0]                    req_data,
  output logic                          EN,
  output logic [1:0]                    cmd,
  output logic [1:0]                    sel,
  output logic [7:0]                    data,
  input  logic                          CS,
  output logic                          busy,
  output logic                          err_timeout,
  input  logic                          err_clr,
  output logic [7:0]                    wiper0,
  output logic [7:0]                    wiper1,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  // Down-counters are loaded with N-1 so the terminal count (0) lands on the
  // N-th cycle spent in the state.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    MIDSCALE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  state_t          r_state;
  logic            r_armed;
  logic [TW-1:0]   r_timer;
  logic [GW-1:0]   r_gap;
  logic            r_en;
  logic [1:0]      r_cmd;
  logic [1:0]      r_sel;
  logic [7:0]      r_data;
  logic            r_err;
  logic [7:0]      r_wiper0;
  logic [7:0]      r_wiper1;

  logic [11:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ready;

  logic            w_push;
  logic            w_pop;
  logic [11:0]     w_head;
  logic            w_head_ok;
  logic [CW-1:0]   w_count_nxt;

  assign w_push    = req_valid & r_ready;
  // CS must read high in IDLE too, so EN can never start on top of a frame.
  assign w_pop     = (r_state == S_IDLE) & r_armed & CS & (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_ok = ((w_head[11:10] == 2'b01) | (w_head[11:10] == 2'b10)) &
                     (w_head[9:8] != 2'b00);

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push & ~w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (~w_push & w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // Request storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk_in) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {req_cmd, req_sel, req_data};
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CW'(FIFO_DEPTH));
    end
  end

  // Frame sequencing FSM with registered transmitter controls, shadows and error flag.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b0;
      r_timer  <= '0;
      r_gap    <= '0;
      r_en     <= 1'b0;
      r_cmd    <= 2'b00;
      r_sel    <= 2'b00;
      r_data   <= 8'h00;
      r_err    <= 1'b0;
      r_wiper0 <= MIDSCALE;
      r_wiper1 <= MIDSCALE;
    end else begin
      r_en <= 1'b0;
      // The transmitter is not reset, so wait for any interrupted frame to end.
      if (CS)
        r_armed <= 1'b1;
      // A timeout set later in this block overrides the clear.
      if (err_clr)
        r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop && w_head_ok) begin
            r_cmd   <= w_head[11:10];
            r_sel   <= w_head[9:8];
            r_data  <= w_head[7:0];
            r_en    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_timer <= TMO_LOAD;
          r_state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!CS) begin
            r_state <= S_WAIT_HIGH;
          end else if (r_timer == '0) begin
            r_err   <= 1'b1;
            r_gap   <= GAP_LOAD;
            r_state <= S_GAP;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (CS) begin
            if (r_cmd == 2'b01) begin
              if (r_sel[0])
                r_wiper0 <= r_data;
              if (r_sel[1])
                r_wiper1 <= r_data;
            end
            r_gap   <= GAP_LOAD;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == '0)
            r_state <= S_IDLE;
          else
            r_gap <= r_gap - GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign fifo_count  = r_count;
  assign busy        = (r_state != S_IDLE) | (r_count != '0);
  assign EN          = r_en;
  assign cmd         = r_cmd;
  assign sel         = r_sel;
  assign data        = r_data;
  assign err_timeout = r_err;
  assign wiper0      = r_wiper0;
  assign wiper1      = r_wiper1;

endmodule

// File: tb/tb_dfr0520_cmd_sequencer.sv
// Bench for dfr0520_cmd_sequencer: behavioural transmitter model on CS plus a
// request-level reference model (expected frame list and shadow values).
module tb_dfr0520_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int TMO   = 15;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_cmd = 2'b00;
  logic [1:0] req_sel = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       CS = 1'b1;
  logic       err_clr = 1'b0;
  logic       req_ready, EN, busy, err_timeout;
  logic [1:0] cmd, sel;
  logic [7:0] data, wiper0, wiper1;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  dfr0520_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_sel(req_sel), .req_data(req_data), .EN(EN),
    .cmd(cmd), .sel(sel), .data(data), .CS(CS), .busy(busy),
    .err_timeout(err_timeout), .err_clr(err_clr), .wiper0(wiper0),
    .wiper1(wiper1), .fifo_count(fifo_count)
  );

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // EN rule monitors
  logic prev_en = 1'b0;
  int   en_cs_bad = 0;
  int   en_dbl = 0;
  always @(posedge clk_in) begin
    if (EN === 1'b1 && CS === 1'b0) en_cs_bad++;
    if (EN === 1'b1 && prev_en) en_dbl++;
    prev_en = (EN === 1'b1);
  end

  // Transmitter model: CS low ~3 clocks after EN, held low 16 clocks, no reset.
  logic        tx_dead = 1'b0;
  logic [11:0] obs_q[$];
  int          gap_q[$];
  int          last_rise = -1;
  initial forever begin
    @(posedge clk_in);
    if (EN === 1'b1 && !tx_dead) begin
      obs_q.push_back({cmd, sel, data});
      repeat (2) @(posedge clk_in);
      #2;
      if (last_rise >= 0) gap_q.push_back(cyc - last_rise);
      CS = 1'b0;
      repeat (16) @(posedge clk_in);
      #2;
      CS = 1'b1;
      last_rise = cyc;
    end
  end

  // Reference model: which requests become frames, and what the shadows become.
  logic [11:0] exp_q[$];
  logic [7:0]  m_w0 = 8'h80;
  logic [7:0]  m_w1 = 8'h80;
  int          last_wait = 0;

  function automatic void model_req(input logic [1:0] c, input logic [1:0] s, input logic [7:0] d);
    if ((c == 2'b01 || c == 2'b10) && s != 2'b00) begin
      exp_q.push_back({c, s, d});
      if (c == 2'b01) begin
        if (s == 2'b01 || s == 2'b11) m_w0 = d;
        if (s == 2'b10 || s == 2'b11) m_w1 = d;
      end
    end
  endfunction

  task automatic push(input logic [1:0] c, input logic [1:0] s, input logic [7:0] d);
    logic r;
    int n;
    req_cmd = c; req_sel = s; req_data = d; req_valid = 1'b1;
    n = 0;
    forever begin
      r = req_ready;
      @(posedge clk_in); #1;
      if (r) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL push_accept waited=%0d cycles, required acceptance", n);
        break;
      end
    end
    req_valid = 1'b0;
    last_wait = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy === 1'b0 && CS === 1'b1)) begin
      @(posedge clk_in); #1;
      n++;
      if (n > 3000) begin
        total++; bad++;
        $display("FAIL wait_idle busy=%b after %0d cycles, required 0", busy, n);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    total++; if ({EN, cmd, sel, data} !== 13'h0) begin bad++;
      $display("FAIL reset_txout got=%h required=0", {EN, cmd, sel, data}); end
    total++; if ({busy, err_timeout, req_ready, fifo_count} !== 6'b001_000) begin bad++;
      $display("FAIL reset_flags got=%b required=001000", {busy, err_timeout, req_ready, fifo_count}); end
    total++; if ({wiper0, wiper1} !== 16'h8080) begin bad++;
      $display("FAIL reset_wipers got=%h required=8080", {wiper0, wiper1}); end
    rst = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic test_single_write();
    int n;
    obs_q.delete(); exp_q.delete();
    model_req(2'b01, 2'b01, 8'h3C);
    push(2'b01, 2'b01, 8'h3C);
    @(posedge clk_in); #1;
    total++; if ({EN, cmd, sel, data} !== {1'b1, 2'b01, 2'b01, 8'h3C}) begin bad++;
      $display("FAIL single_en_pulse got=%h required=%h", {EN, cmd, sel, data}, {1'b1, 2'b01, 2'b01, 8'h3C}); end
    total++; if (fifo_count !== 3'd0) begin bad++;
      $display("FAIL single_popped count=%0d required=0", fifo_count); end
    @(posedge clk_in); #1;
    total++; if (EN !== 1'b0) begin bad++;
      $display("FAIL single_en_width EN=%b required=0", EN); end
    n = 0;
    while (CS !== 1'b0 && n < 30) begin @(posedge clk_in); #1; n++; end
    while (CS !== 1'b1 && n < 60) begin @(posedge clk_in); #1; n++; end
    total++; if (n >= 60) begin bad++;
      $display("FAIL single_frame_end CS=%b after %0d cycles, required a full frame", CS, n); end
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL single_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
    @(posedge clk_in); #1;
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL single_busy_gap busy=%b required=1", busy); end
    @(posedge clk_in); #1;
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL single_busy_drop busy=%b required=0", busy); end
    total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin bad++;
      $display("FAIL single_frame n=%0d first=%h required=%h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 12'h0, exp_q[0]); end
  endtask

  task automatic test_fifo_full();
    logic [1:0] c, s;
    logic [7:0] d;
    obs_q.delete(); exp_q.delete(); gap_q.delete();
    c = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    s = 2'($urandom_range(1, 3)); d = 8'($urandom);
    model_req(c, s, d); push(c, s, d);
    repeat (3) @(posedge clk_in);
    #1;
    for (int i = 0; i < 5; i++) begin
      c = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      s = 2'($urandom_range(1, 3)); d = 8'($urandom);
      model_req(c, s, d); push(c, s, d);
      if (i == 3) begin
        total++; if ({fifo_count, req_ready} !== {3'd4, 1'b0}) begin bad++;
          $display("FAIL full_ready count=%0d ready=%b required 4/0", fifo_count, req_ready); end
      end
    end
    total++; if (last_wait == 0) begin bad++;
      $display("FAIL full_fifth_held waited=%0d required>0", last_wait); end
    wait_idle();
    total++; if (obs_q.size() != exp_q.size()) begin bad++;
      $display("FAIL full_frames count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL full_frame[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    foreach (gap_q[i]) begin
      total++; if (gap_q[i] < GAP) begin bad++;
        $display("FAIL full_cs_gap[%0d] got=%0d required>=%0d", i, gap_q[i], GAP); end
    end
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL full_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
  endtask

  task automatic test_both_then_shutdown();
    obs_q.delete(); exp_q.delete();
    model_req(2'b01, 2'b11, 8'hFF); push(2'b01, 2'b11, 8'hFF);
    wait_idle();
    total++; if ({wiper0, wiper1} !== 16'hFFFF) begin bad++;
      $display("FAIL both_shadows got=%h required=FFFF", {wiper0, wiper1}); end
    model_req(2'b10, 2'b01, 8'h00); push(2'b10, 2'b01, 8'h00);
    wait_idle();
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL shutdown_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
    total++; if (obs_q.size() != 2 || obs_q[1] !== exp_q[1]) begin bad++;
      $display("FAIL shutdown_frame n=%0d required=2 frames", obs_q.size()); end
  endtask

  task automatic test_invalid();
    obs_q.delete(); exp_q.delete();
    model_req(2'b00, 2'b01, 8'h11); push(2'b00, 2'b01, 8'h11);
    model_req(2'b01, 2'b00, 8'h22); push(2'b01, 2'b00, 8'h22);
    model_req(2'b11, 2'b11, 8'h33); push(2'b11, 2'b11, 8'h33);
    model_req(2'b10, 2'b00, 8'h44); push(2'b10, 2'b00, 8'h44);
    repeat (4) @(posedge clk_in);
    #1;
    wait_idle();
    total++; if (obs_q.size() != exp_q.size()) begin bad++;
      $display("FAIL invalid_no_en frames=%0d required=%0d", obs_q.size(), exp_q.size()); end
    total++; if ({fifo_count, err_timeout} !== 4'b000_0) begin bad++;
      $display("FAIL invalid_drain count=%0d err=%b required 0/0", fifo_count, err_timeout); end
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL invalid_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
  endtask

  task automatic test_random_mix();
    logic [1:0] c, s;
    logic [7:0] d;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      c = 2'($urandom_range(0, 3)); s = 2'($urandom_range(0, 3)); d = 8'($urandom);
      model_req(c, s, d); push(c, s, d);
      repeat ($urandom_range(0, 3)) @(posedge clk_in);
      #0;
    end
    wait_idle();
    total++; if (obs_q.size() != exp_q.size()) begin bad++;
      $display("FAIL mix_frames count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL mix_frame[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL mix_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
  endtask

  task automatic test_timeout();
    int c_en, c_err;
    bit seen;
    tx_dead = 1'b1;
    push(2'b01, 2'b01, 8'h5A);
    c_en = -1; c_err = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_in); #1;
      if (EN === 1'b1 && c_en < 0) c_en = i;
      if (err_timeout === 1'b1) begin c_err = i; break; end
    end
    total++; if (c_en < 0 || c_err - c_en != TMO + 1) begin bad++;
      $display("FAIL timeout_latency en=%0d err=%0d required err-en=%0d", c_en, c_err, TMO + 1); end
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL timeout_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
    @(posedge clk_in); #1;
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL timeout_gap busy=%b required=1", busy); end
    @(posedge clk_in); #1;
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL timeout_idle busy=%b required=0", busy); end
    err_clr = 1'b1;
    @(posedge clk_in); #1;
    err_clr = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++;
      $display("FAIL timeout_clear err=%b required=0", err_timeout); end
    err_clr = 1'b1;
    push(2'b01, 2'b10, 8'hA5);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in); #1;
      if (err_timeout === 1'b1) begin seen = 1; break; end
    end
    err_clr = 1'b0;
    total++; if (!seen) begin bad++;
      $display("FAIL timeout_set_wins err=%b required=1", err_timeout); end
    @(posedge clk_in); #1;
    total++; if (err_timeout !== 1'b1) begin bad++;
      $display("FAIL timeout_sticky err=%b required=1", err_timeout); end
    wait_idle();
    tx_dead = 1'b0;
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL timeout_shadows2 got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
  endtask

  task automatic test_reset_mid_frame();
    int n, en_early;
    obs_q.delete(); exp_q.delete();
    model_req(2'b01, 2'b11, 8'h21); push(2'b01, 2'b11, 8'h21);
    n = 0;
    while (CS !== 1'b0 && n < 30) begin @(posedge clk_in); #1; n++; end
    push(2'b01, 2'b01, 8'h42);
    push(2'b01, 2'b10, 8'h43);
    total++; if (fifo_count !== 3'd2) begin bad++;
      $display("FAIL midrst_queued count=%0d required=2", fifo_count); end
    rst = 1'b1;
    #1;
    total++; if ({EN, cmd, sel, data, busy, err_timeout, req_ready, fifo_count} !== {13'h0, 6'b001_000}) begin bad++;
      $display("FAIL midrst_outputs got=%h required=%h", {EN, cmd, sel, data, busy, err_timeout, req_ready, fifo_count}, {13'h0, 6'b001_000}); end
    m_w0 = 8'h80; m_w1 = 8'h80;
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL midrst_wipers got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
    @(posedge clk_in); #1;
    rst = 1'b0;
    total++; if (CS !== 1'b0) begin bad++;
      $display("FAIL midrst_cs_low CS=%b required=0 after reset release", CS); end
    model_req(2'b01, 2'b01, 8'h99); push(2'b01, 2'b01, 8'h99);
    en_early = 0; n = 0;
    while (CS !== 1'b1 && n < 40) begin
      if (EN === 1'b1) en_early++;
      @(posedge clk_in); #1; n++;
    end
    total++; if (en_early != 0) begin bad++;
      $display("FAIL midrst_no_en_before_cs en_cycles=%0d required=0", en_early); end
    wait_idle();
    total++; if (obs_q.size() != exp_q.size()) begin bad++;
      $display("FAIL midrst_frames count got=%0d required=%0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL midrst_frame[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if ({wiper0, wiper1} !== {m_w0, m_w1}) begin bad++;
      $display("FAIL midrst_shadows got=%h required=%h", {wiper0, wiper1}, {m_w0, m_w1}); end
  endtask

  task automatic test_en_rules();
    total++; if (en_cs_bad != 0) begin bad++;
      $display("FAIL en_while_cs_low count=%0d required=0", en_cs_bad); end
    total++; if (en_dbl != 0) begin bad++;
      $display("FAIL en_consecutive count=%0d required=0", en_dbl); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fifo_full();
    test_both_then_shutdown();
    test_invalid();
    test_random_mix();
    test_timeout();
    test_reset_mid_frame();
    test_en_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, required completion");
    $fatal(1);
  end

endmodule
